// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared SRAM controller/arbiter widths, command direction codes and arbiter states
package sram_pkg;

  // Default widths, matching the controller address bus and data bus
  localparam int AW_DEF = 18;
  localparam int DW_DEF = 16;

  // Command direction encoding shared with the controller
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Arbiter sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } arb_state_e;

  // Index of the port a request was granted to, as a one-hot ack/done pair
  function automatic logic [1:0] port_onehot(input logic port);
    port_onehot = port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sram_arb_grant.sv
// rtl/sram_arb_grant.sv - combinational grant picker; SRAM_ARB_RR_EN selects round-robin over fixed priority
module sram_arb_grant
  import sram_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_o
);

`ifdef SRAM_ARB_RR_EN
  // Round-robin: on a tie the port not granted last wins; a lone requester always wins
  always_comb begin
    grant_o = 1'b0;
    if (req0_i && req1_i) begin
      grant_o = ~last_grant_i;
    end else if (req1_i) begin
      grant_o = 1'b1;
    end
  end
`else
  // The pointer has no meaning under fixed priority
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  // Fixed priority: port 0 wins whenever it is requesting
  always_comb begin
    grant_o = 1'b0;
    if (!req0_i && req1_i) begin
      grant_o = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/sram_arbiter_2p.sv
// rtl/sram_arbiter_2p.sv - two-port single-word arbiter/sequencer for the SRAM controller user port (SRAM_ARB_RR_EN: round-robin)
module sram_arbiter_2p
  import sram_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          rw0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          rw1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          done0,
  output logic          done1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem,
  output logic          rw,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_f2s,
  input  logic          ready,
  input  logic [DW-1:0] data_s2f
);

  // Watchdog counts WAIT cycles; it stops at abort so it never wraps
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  logic          grant_q, grant_d;
  logic          lat_rw_q, lat_rw_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic          mem_q, mem_d;
  logic          rw_q, rw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [1:0]    ack_q, ack_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic          take;
  logic          grant_pick;
  logic          last_grant;

  // A new command can start only from IDLE while the controller is accepting
  assign take = (state_q == ST_IDLE) && ready && (req0 || req1);

  sram_arb_grant u_grant (
    .req0_i       (req0),
    .req1_i       (req1),
    .last_grant_i (last_grant),
    .grant_o      (grant_pick)
  );

`ifdef SRAM_ARB_RR_EN
  logic last_q, last_d;

  assign last_d     = take ? grant_pick : last_q;
  assign last_grant = last_q;

  // Pointer remembers the most recently granted port; reset value lets port 0 win the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign last_grant = 1'b1;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus next values of every registered output and latched field
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    lat_rw_d = lat_rw_q;
    wd_d     = wd_q;
    mem_d    = 1'b0;
    rw_d     = RW_READ;
    addr_d   = addr_q;
    data_d   = data_q;
    ack_d    = 2'b00;
    done_d   = 2'b00;
    err_d    = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d  = ST_ISSUE;
          grant_d  = grant_pick;
          lat_rw_d = grant_pick ? rw1 : rw0;
          addr_d   = grant_pick ? addr1 : addr0;
          data_d   = grant_pick ? wdata1 : wdata0;
          mem_d    = 1'b1;
          rw_d     = grant_pick ? rw1 : rw0;
          ack_d    = port_onehot(grant_pick);
        end
      end
      ST_ISSUE: begin
        state_d = ST_GUARD;
      end
      ST_GUARD: begin
        // The controller drops ready a cycle late, so ready is not trusted here
        state_d = ST_WAIT;
        wd_d    = '0;
      end
      ST_WAIT: begin
        if (ready) begin
          state_d = ST_IDLE;
          done_d  = port_onehot(grant_q);
          if (lat_rw_q == RW_READ) begin
            if (grant_q) begin
              rdata1_d = data_s2f;
            end else begin
              rdata0_d = data_s2f;
            end
          end
        end else if (wd_q == WD_LAST) begin
          state_d = ST_IDLE;
          done_d  = port_onehot(grant_q);
          err_d   = port_onehot(grant_q);
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers; reset clears everything at once so mem drops immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q  <= 1'b0;
      lat_rw_q <= RW_READ;
      wd_q     <= '0;
      mem_q    <= 1'b0;
      rw_q     <= RW_READ;
      addr_q   <= '0;
      data_q   <= '0;
      ack_q    <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      grant_q  <= grant_d;
      lat_rw_q <= lat_rw_d;
      wd_q     <= wd_d;
      mem_q    <= mem_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign mem      = mem_q;
  assign rw       = rw_q;
  assign addr     = addr_q;
  assign data_f2s = data_q;
  assign ack0     = ack_q[0];
  assign ack1     = ack_q[1];
  assign done0    = done_q[0];
  assign done1    = done_q[1];
  assign err0     = err_q[0];
  assign err1     = err_q[1];
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// tb/tb_sram_arbiter_2p.sv - self-checking bench for sram_arbiter_2p with a behavioural controller and reference memory
module tb_sram_arbiter_2p;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, rw0, req1, rw1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, done0, done1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem, rw;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_f2s;
  logic          ready;
  logic [DW-1:0] data_s2f;

  sram_arbiter_2p #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
    .mem(mem), .rw(rw), .addr(addr), .data_f2s(data_f2s),
    .ready(ready), .data_s2f(data_s2f)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Controller model state
  bit            ctl_pend, ctl_busy, ctl_hang;
  int            ctl_cnt, ctl_lat;
  logic [AW-1:0] ctl_addr;
  logic          ctl_rw;
  logic [DW-1:0] ctl_mem [16];

  // Reference model and monitor state
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] exp_rd0, exp_rd1;
  int            n_mem, n_ack0, n_ack1, n_done0, n_done1;
  int            ack0_cyc, ack1_cyc, done0_cyc, done1_cyc, mem_cyc, last_mem_cyc;
  logic          err0_seen, err1_seen;
  bit            outstanding, auto_drop;
  int            rw_viol, overlap_viol, spacing_viol, err_viol;
  logic [AW-1:0] mem_addr_seen;
  logic          mem_rw_seen;
  logic [DW-1:0] mem_data_seen;
  int            ack_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ready        = 1'b1;
    data_s2f     = '0;
    ctl_pend     = 1'b0;
    ctl_busy     = 1'b0;
    ctl_hang     = 1'b0;
    outstanding  = 1'b0;
    last_mem_cyc = -100;
    req0         = 1'b0;
    req1         = 1'b0;
    exp_rd0      = '0;
    exp_rd1      = '0;
  endtask

  // One clock: advance the controller model, then observe DUT outputs for this cycle
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (ctl_pend) begin
      ready    = 1'b0;
      ctl_busy = 1'b1;
      ctl_pend = 1'b0;
      data_s2f = DW'($urandom);
    end else if (ctl_busy && !ctl_hang) begin
      if (ctl_cnt == 0) begin
        ready    = 1'b1;
        ctl_busy = 1'b0;
        if (ctl_rw) data_s2f = ctl_mem[ctl_addr[3:0]];
      end else begin
        ctl_cnt--;
      end
    end
    if (mem === 1'b1) begin
      n_mem++;
      if (outstanding) overlap_viol++;
      if (cyc - last_mem_cyc < 4) spacing_viol++;
      last_mem_cyc  = cyc;
      mem_cyc       = cyc;
      outstanding   = 1'b1;
      mem_addr_seen = addr;
      mem_rw_seen   = rw;
      mem_data_seen = data_f2s;
      ctl_pend      = 1'b1;
      ctl_addr      = addr;
      ctl_rw        = rw;
      ctl_cnt       = ctl_lat;
      if (rw === 1'b0) ctl_mem[addr[3:0]] = data_f2s;
    end else if (rw !== 1'b1) begin
      rw_viol++;
    end
    if (ack0 === 1'b1) begin
      n_ack0++; ack0_cyc = cyc; ack_q.push_back(0);
      if (auto_drop) req0 = 1'b0;
    end
    if (ack1 === 1'b1) begin
      n_ack1++; ack1_cyc = cyc; ack_q.push_back(1);
      if (auto_drop) req1 = 1'b0;
    end
    if (done0 === 1'b1) begin n_done0++; done0_cyc = cyc; err0_seen = err0; outstanding = 1'b0; end
    if (done1 === 1'b1) begin n_done1++; done1_cyc = cyc; err1_seen = err1; outstanding = 1'b0; end
    if ((err0 === 1'b1 && done0 !== 1'b1) || (err1 === 1'b1 && done1 !== 1'b1)) err_viol++;
  endtask

  // Issue one request on port p and follow it to done; reference memory is updated from the stimulus
  task automatic do_txn(input int p, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int lat, input bit abort, output int rc, output int ac, output int dc,
                        output logic e);
    int na, nd, k;
    ctl_lat = lat;
    na = (p == 0) ? n_ack0 : n_ack1;
    nd = (p == 0) ? n_done0 : n_done1;
    if (p == 0) begin rw0 = r; addr0 = a; wdata0 = d; req0 = 1'b1; end
    else        begin rw1 = r; addr1 = a; wdata1 = d; req1 = 1'b1; end
    rc = cyc;
    k = 0;
    while (((p == 0) ? n_ack0 : n_ack1) == na && k < 100) begin step(); k++; end
    chk("ack_arrived", 32'(((p == 0) ? n_ack0 : n_ack1) - na), 1);
    req0 = (p == 0) ? 1'b0 : req0;
    req1 = (p == 1) ? 1'b0 : req1;
    k = 0;
    while (((p == 0) ? n_done0 : n_done1) == nd && k < 100) begin step(); k++; end
    chk("done_arrived", 32'(((p == 0) ? n_done0 : n_done1) - nd), 1);
    ac = (p == 0) ? ack0_cyc : ack1_cyc;
    dc = (p == 0) ? done0_cyc : done1_cyc;
    e  = (p == 0) ? err0_seen : err1_seen;
    if (!abort) begin
      if (r == 1'b0) ref_mem[a[3:0]] = d;
      else if (p == 0) exp_rd0 = ref_mem[a[3:0]];
      else exp_rd1 = ref_mem[a[3:0]];
    end
  endtask

  initial begin
    int rc, ac, dc, k, na, nd, na1, nd1, nm, p, lat, last, w;
    logic e, r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    for (int i = 0; i < 16; i++) begin ctl_mem[i] = '0; ref_mem[i] = '0; end
    auto_drop = 1'b1;
    rw0 = 1'b0; addr0 = '0; wdata0 = '0; rw1 = 1'b0; addr1 = '0; wdata1 = '0;
    ctl_lat = 0;
    model_reset();
    reset = 1'b1;
    step(); step();

    // Reset values
    chk("rst_mem", 32'(mem), 0);
    chk("rst_rw", 32'(rw), 1);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_data_f2s", 32'(data_f2s), 0);
    chk("rst_pulses", 32'({ack0, ack1, done0, done1, err0, err1}), 0);
    chk("rst_rdata0", 32'(rdata0), 0);
    chk("rst_rdata1", 32'(rdata1), 0);
    reset = 1'b0;
    step();

    // Single write on port 0
    do_txn(0, 1'b0, 18'h000F0, 16'h00A5, 1, 1'b0, rc, ac, dc, e);
    chk("wr_ack_lat", 32'(ac - rc), 1);
    chk("wr_mem_cyc", 32'(mem_cyc - ac), 0);
    chk("wr_addr", 32'(mem_addr_seen), 32'h000F0);
    chk("wr_data", 32'(mem_data_seen), 32'h00A5);
    chk("wr_rw", 32'(mem_rw_seen), 0);
    chk("wr_done_lat", 32'(dc - ac), 3 + 1);
    chk("wr_err", 32'(e), 0);

    // Read-back on port 1
    do_txn(1, 1'b1, 18'h000F0, 16'h0000, 2, 1'b0, rc, ac, dc, e);
    chk("rd_ack_lat", 32'(ac - rc), 1);
    chk("rd_rw", 32'(mem_rw_seen), 1);
    chk("rd_done_lat", 32'(dc - ac), 3 + 2);
    chk("rd_rdata1", 32'(rdata1), 32'h00A5);
    chk("rd_rdata0_held", 32'(rdata0), 0);

    // Randomized serial traffic against the reference memory
    for (int i = 0; i < 24; i++) begin
      p   = int'($urandom_range(0, 1));
      r   = 1'($urandom_range(0, 1));
      a   = AW'($urandom);
      d   = DW'($urandom);
      lat = int'($urandom_range(0, 3));
      do_txn(p, r, a, d, lat, 1'b0, rc, ac, dc, e);
      chk("rnd_ack_lat", 32'(ac - rc), 1);
      chk("rnd_done_lat", 32'(dc - ac), 32'(3 + lat));
      chk("rnd_err", 32'(e), 0);
      chk("rnd_mem_addr", 32'(mem_addr_seen), 32'(a));
      chk("rnd_mem_rw", 32'(mem_rw_seen), 32'(r));
      if (r == 1'b0) chk("rnd_mem_data", 32'(mem_data_seen), 32'(d));
      chk("rnd_rdata0", 32'(rdata0), 32'(exp_rd0));
      chk("rnd_rdata1", 32'(rdata1), 32'(exp_rd1));
    end

    // Watchdog abort with the controller hung
    ctl_hang = 1'b1;
    do_txn(0, 1'b1, 18'h2A5A5, 16'h0000, 0, 1'b1, rc, ac, dc, e);
    chk("to_done_lat", 32'(dc - ac), TO + 2);
    chk("to_err", 32'(e), 1);
    chk("to_rdata0_held", 32'(rdata0), 32'(exp_rd0));
    ctl_hang = 1'b0;
    ctl_busy = 1'b0;
    ready    = 1'b1;
    do_txn(0, 1'b0, 18'h00123, 16'hBEEF, 2, 1'b0, rc, ac, dc, e);
    chk("post_to_ack_lat", 32'(ac - rc), 1);
    chk("post_to_done_lat", 32'(dc - ac), 3 + 2);
    chk("post_to_err", 32'(e), 0);

    // Busy hold-off: port 1 raises its request during port 0's WAIT
    ctl_lat = 4;
    na = n_ack0; nd = n_done0;
    rw0 = 1'b0; addr0 = 18'h00305; wdata0 = 16'h1234; req0 = 1'b1;
    k = 0;
    while (n_ack0 == na && k < 50) begin step(); k++; end
    chk("ho_ack0", 32'(n_ack0 - na), 1);
    nm = n_mem;
    step(); step(); step();
    na1 = n_ack1; nd1 = n_done1;
    rw1 = 1'b1; addr1 = 18'h00305; wdata1 = 16'h0000; req1 = 1'b1;
    k = 0;
    while (n_done0 == nd && k < 50) begin step(); k++; end
    chk("ho_done0", 32'(n_done0 - nd), 1);
    chk("ho_no_ack1_early", 32'(n_ack1 - na1), 0);
    chk("ho_no_mem_in_wait", 32'(n_mem - nm), 0);
    ref_mem[5] = 16'h1234;
    k = 0;
    while (n_ack1 == na1 && k < 50) begin step(); k++; end
    chk("ho_ack1_after_done", 32'(ack1_cyc - done0_cyc), 1);
    k = 0;
    while (n_done1 == nd1 && k < 50) begin step(); k++; end
    exp_rd1 = 16'h1234;
    chk("ho_rdata1", 32'(rdata1), 32'h1234);
    chk("ho_rdata0_held", 32'(rdata0), 32'(exp_rd0));

    // Reset during WAIT
    ctl_lat = 6;
    na = n_ack0; nd = n_done0;
    rw0 = 1'b1; addr0 = 18'h00007; req0 = 1'b1;
    k = 0;
    while (n_ack0 == na && k < 50) begin step(); k++; end
    step(); step();
    #3 reset = 1'b1;
    #1;
    chk("rstw_mem", 32'(mem), 0);
    chk("rstw_rw", 32'(rw), 1);
    model_reset();
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("rstw_no_done", 32'(n_done0 - nd), 0);
    chk("rstw_rdata0", 32'(rdata0), 32'(exp_rd0));
    do_txn(1, 1'b0, 18'h00009, 16'h5A5A, 0, 1'b0, rc, ac, dc, e);
    chk("rstw_ack1_lat", 32'(ac - rc), 1);
    chk("rstw_err1", 32'(e), 0);

    // Reset while the command strobe is high must drop it before the next edge
    ctl_lat = 0;
    na = n_ack0;
    rw0 = 1'b0; addr0 = 18'h0000A; wdata0 = 16'h7777; req0 = 1'b1;
    k = 0;
    while (n_ack0 == na && k < 50) begin step(); k++; end
    chk("rsti_mem_before", 32'(mem), 1);
    #2 reset = 1'b1;
    #1;
    chk("rsti_mem_async", 32'(mem), 0);
    chk("rsti_ack_async", 32'(ack0), 0);
    model_reset();
    step();
    reset = 1'b0;

    // Contention from a fresh reset so the first tie favours port 0
    model_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    auto_drop = 1'b0;
    ctl_lat = int'($urandom_range(0, 2));
    rw0 = 1'b0; addr0 = 18'h00011; wdata0 = 16'h0A0A;
    rw1 = 1'b0; addr1 = 18'h00012; wdata1 = 16'h0B0B;
    ack_q.delete();
    req0 = 1'b1; req1 = 1'b1;
    k = 0;
    while (ack_q.size() < 4 && k < 200) begin step(); k++; end
    req0 = 1'b0;
    chk("ct_count", 32'(ack_q.size()), 4);
    last = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_RR_EN
      w = 1 - last;
`else
      w = 0;
`endif
      last = w;
      if (i < ack_q.size()) chk("ct_order", 32'(ack_q[i]), 32'(w));
    end
    k = 0;
    while (ack_q.size() < 5 && k < 200) begin step(); k++; end
    req1 = 1'b0;
    chk("ct_fifth_count", 32'(ack_q.size()), 5);
    if (ack_q.size() > 4) chk("ct_fifth_port", 32'(ack_q[4]), 1);
    k = 0;
    while (outstanding && k < 100) begin step(); k++; end
    chk("ct_drain", 32'(outstanding), 0);
    auto_drop = 1'b1;

    // Invariants watched every cycle
    chk("rw_high_when_idle", 32'(rw_viol), 0);
    chk("no_mem_while_busy", 32'(overlap_viol), 0);
    chk("issue_spacing", 32'(spacing_viol), 0);
    chk("err_only_with_done", 32'(err_viol), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/sram_arbiter_2p.md
# sram_arbiter_2p

Two-port arbiter and sequencer for the SRAM controller's user port (mem/rw/addr/data_f2s/ready/data_s2f_r). It takes single-word read/write requests from two independent requesters, grants one at a time, and issues the command to the controller. It tracks the command to completion, returns read data per port, and aborts hung transactions with a watchdog. It sits between the user logic and the controller, in the controller's clock domain.

## Interface
- AW, 18, address width (matches controller `ad`)
- DW, 16, data width (matches controller `dio_a`)
- TIMEOUT, 64, maximum WAIT cycles before abort (≥4)
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high
- req0 / req1  in  1  request; held with fields stable until ack
- rw0 / rw1  in  1  1 = read, 0 = write
- addr0 / addr1  in  AW  word address
- wdata0 / wdata1  in  DW  write data
- ack0 / ack1  out  1  one-cycle pulse: request accepted, fields latched
- done0 / done1  out  1  one-cycle pulse: transaction finished (or aborted)
- err0 / err1  out  1  valid with done; 1 = watchdog abort
- rdata0 / rdata1  out  DW  read data, updated on read done, held otherwise
- mem  out  1  command strobe to controller, one cycle
- rw  out  1  command direction to controller
- addr  out  AW  command address to controller
- data_f2s  out  DW  write data to controller
- ready  in  1  controller idle/accepting; registered data valid when high
- data_s2f  in  DW  controller registered read data

## Operation
- FSM states: IDLE, ISSUE, GUARD, WAIT.
- IDLE: if ready=1 and any req is high, pick a grant, latch rw/addr/wdata of the granted port, and go to ISSUE. Otherwise stay.
- ISSUE (1 cycle): mem=1, rw/addr/data_f2s = latched values, ack of the granted port = 1. Next state is GUARD.
- GUARD (1 cycle): ready is ignored, because the controller drops ready the cycle after it accepts. Next state is WAIT.
- WAIT: when ready=1, a read latches data_s2f into rdata of the granted port. done of that port pulses next cycle, err=0, and the FSM returns to IDLE.
- Watchdog: counter cleared on entering WAIT, incremented each WAIT cycle. When it reaches TIMEOUT-1 with ready still 0, done and err pulse together, rdata is unchanged, and the FSM returns to IDLE.
- Arbitration: only the active grant policy (see Configuration) decides between simultaneous requests. A single requester always wins.
- The latched grant is stable from IDLE exit until done. Requesters may change fields after ack.
- When mem=0: rw=1, and addr and data_f2s hold their last values.

## Timing
- Reset values: state IDLE, mem=0, rw=1, addr=0, data_f2s=0, all ack/done/err=0, rdata0=rdata1=0, RR pointer favours port 0, watchdog=0.
- All outputs are registered.
- req sampled high at edge k with ready=1 in IDLE → ack and mem high during cycle k+1.
- Controller ready high in WAIT at edge m → done (and rdata if read) visible in cycle m+1. FSM is in IDLE at m+1 and can accept again at edge m+1.
- Minimum issue-to-issue spacing is 4 cycles.
- A request raised while the FSM is busy waits. A requester that drops req before ack is not serviced.
- Reset mid-transaction drops everything immediately: no done or err pulse, and mem goes low asynchronously.
- Watchdog count width is clog2(TIMEOUT). There is no wrap, because the counter stops at abort.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin. On simultaneous requests, the port not granted last wins; the pointer updates on each ack.
- SRAM_ARB_RR_EN not defined: fixed priority, port 0 always wins. The pointer logic is not compiled.

## Structure
- Shared package sram_pkg holds:
  - AW/DW defaults
  - the state enum localparams (IDLE, ISSUE, GUARD, WAIT)
  - the RW_READ=1 / RW_WRITE=0 constants used by the controller and this block
- One sub-module: sram_arb_grant, the combinational grant picker. Inputs are req0, req1 and the last-grant pointer; output is the grant index. It contains the `ifdef`.
- Everything else lives in sram_arbiter_2p.

## Test plan
- Single write: after reset, req0 with rw0=0, addr0=0x000F0, wdata0=0x00A5. Expect ack0 and mem the next cycle with addr=0x000F0 and data_f2s=0x00A5. Expect done0 one cycle after ready returns, err0=0.
- Read-back: req1 with rw1=1, addr1=0x000F0, and the controller model returns 0x00A5. Expect rdata1=0x00A5 on done1, and rdata0 unchanged.
- Contention: req0 and req1 held together for 4 transactions.
  - With SRAM_ARB_RR_EN, the ack order is 0,1,0,1.
  - Without it, the order is 0,0,0,0 while req0 is held, and port 1 is served only after req0 drops.
- Timeout: the controller model holds ready=0 after accepting. Expect done0=err0=1 exactly TIMEOUT WAIT cycles later, rdata0 unchanged, and the next request accepted normally.
- Reset mid-WAIT: assert reset in WAIT. Expect mem=0, rw=1, no done pulse, state IDLE. A new req1 after release gets ack1.
- Busy hold-off: raise req1 during port 0's WAIT. Expect ack1 only after done0 and no second mem while WAIT is active.
